// File: rtl/quad_encoder_tx.sv
// Quadrature generator: emits Gray-coded detent cycles on ROT_A/ROT_B for a
// (direction, detent count) command and tracks the net detent position mod 128.
module quad_encoder_tx #(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_steps,
    output logic       ROT_A,
    output logic       ROT_B,
    output logic       busy,
    output logic       done,
    output logic [6:0] position
);

    localparam int unsigned MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       steps_q, steps_d;
    logic             dir_q, dir_d;
    logic [6:0]       pos_q, pos_d;
    logic             done_q, done_d;
    logic [1:0]       rot_q, rot_d;

    // State register; rot and done are registered so the pins are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            done_q  <= 1'b0;
            rot_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            rot_q   <= rot_d;
        end
    end

    // Next-state: dwell counter, detent bookkeeping and command acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        steps_d = steps_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    dir_d = cmd_dir;
                    if (cmd_steps != 7'd0) begin
                        steps_d = cmd_steps;
                        state_d = StPh1;
                    end else begin
                        // Zero-step command completes immediately without touching ROT.
                        done_d = 1'b1;
                    end
                end
            end
            StPh1: begin
                if (cnt_q == PH_LAST) begin
                    cnt_d   = '0;
                    state_d = StPh2;
                end
            end
            StPh2: begin
                if (cnt_q == PH_LAST) begin
                    cnt_d   = '0;
                    state_d = StPh3;
                end
            end
            StPh3: begin
                if (cnt_q == PH_LAST) begin
                    cnt_d   = '0;
                    state_d = StGap;
                    steps_d = steps_q - 7'd1;
                    pos_d   = dir_q ? (pos_q - 7'd1) : (pos_q + 7'd1);
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (steps_q != 7'd0) begin
                        state_d = StPh1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Channel pattern decoded from the next state so ROT moves on the same edge as the FSM.
    always_comb begin
        rot_d = 2'b00;
        case (state_d)
            StPh1:   rot_d = dir_d ? 2'b01 : 2'b10;
            StPh2:   rot_d = 2'b11;
            StPh3:   rot_d = dir_d ? 2'b10 : 2'b01;
            default: rot_d = 2'b00;
        endcase
    end

    assign ROT_A     = rot_q[1];
    assign ROT_B     = rot_q[0];
    assign busy      = (state_q != StIdle);
    assign cmd_ready = (state_q == StIdle);
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Self-checking bench for quad_encoder_tx: table of commands with hand-computed
// completion cycle and final position, plus back-to-back and mid-command reset cases.
module tb_quad_encoder_tx;

    localparam int P   = 4;
    localparam int G   = 8;
    localparam int PER = 3 * P + G;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [6:0] cmd_steps = 7'd0;
    logic       ROT_A;
    logic       ROT_B;
    logic       busy;
    logic       done;
    logic [6:0] position;

    int n_chk  = 0;
    int n_pass = 0;

    quad_encoder_tx #(
        .PHASE_CYCLES(P),
        .GAP_CYCLES  (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_steps(cmd_steps),
        .ROT_A    (ROT_A),
        .ROT_B    (ROT_B),
        .busy     (busy),
        .done     (done),
        .position (position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected {A,B} t cycles after the acceptance edge (t=1 is the first cycle).
    function automatic logic [1:0] exp_rot(input bit dir, input int steps, input int t);
        int d;
        if (t > steps * PER) return 2'b00;
        d = (t - 1) % PER;
        if (d < P)     return dir ? 2'b01 : 2'b10;
        if (d < 2 * P) return 2'b11;
        if (d < 3 * P) return dir ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // Expected position: one step per detent whose gap has started by cycle t.
    function automatic logic [6:0] exp_pos(input bit dir, input int steps, input logic [6:0] p0,
                                           input int t);
        int n = 0;
        for (int i = 0; i < steps; i++) begin
            if (t >= i * PER + 3 * P + 1) n++;
        end
        return dir ? (p0 - 7'(n)) : (p0 + 7'(n));
    endfunction

    // Check every cycle after acceptance up to last_t (stops early if last_t < done_t).
    task automatic track(input bit dir, input int steps, input logic [6:0] p0, input int done_t,
                         input logic [6:0] pos_end, input int last_t);
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            chk("rot", {ROT_A, ROT_B}, exp_rot(dir, steps, t));
            chk("position", position, exp_pos(dir, steps, p0, t));
            chk("busy", busy, (t < done_t) ? 1 : 0);
            chk("done", done, (t == done_t) ? 1 : 0);
            chk("cmd_ready", cmd_ready, (t >= done_t) ? 1 : 0);
            if (t == done_t) chk("pos_end", position, pos_end);
        end
    endtask

    task automatic run_cmd(input bit dir, input int steps, input logic [6:0] p0, input int done_t,
                           input logic [6:0] pos_end);
        @(negedge clk);
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = 7'(steps);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        track(dir, steps, p0, done_t, pos_end, done_t);
    endtask

    // Protocol monitor: Gray transitions, dwell lengths, done shape.
    logic [1:0] prev_rot = 2'b00;
    bit         prev_rst_low = 1'b1;
    bit         prev_done = 1'b0;
    bit         run_valid = 1'b0;
    int         run_len = 0;
    int         gap_busy = 0;

    always @(negedge clk) begin
        logic [1:0] cur;
        cur = {ROT_A, ROT_B};
        if (!rst_n || prev_rst_low) begin
            run_valid = 1'b0;
            run_len   = 1;
            gap_busy  = 0;
        end else if (cur != prev_rot) begin
            chk("one_channel", $countones(cur ^ prev_rot), 1);
            if (run_valid) begin
                if (prev_rot != 2'b00) chk("phase_len", run_len, P);
                else if (gap_busy > 0) chk("gap_len", gap_busy, G);
            end
            run_valid = 1'b1;
            run_len   = 1;
            gap_busy  = (cur == 2'b00 && busy) ? 1 : 0;
        end else begin
            run_len++;
            if (cur == 2'b00 && busy) gap_busy++;
        end
        if (rst_n && done) begin
            chk("done_not_busy", busy, 0);
            chk("done_width", prev_done, 0);
        end
        prev_rot     = cur;
        prev_rst_low = !rst_n;
        prev_done    = done;
    end

    typedef struct {
        bit         dir;
        int         steps;
        int         done_t;
        logic [6:0] pos_end;
    } vec_t;

    vec_t       vecs[6];
    logic [6:0] pos_model;

    initial begin
        vecs[0] = '{dir: 1'b0, steps: 3, done_t: 61, pos_end: 7'd3};
        vecs[1] = '{dir: 1'b0, steps: 0, done_t: 1,  pos_end: 7'd3};
        vecs[2] = '{dir: 1'b1, steps: 2, done_t: 41, pos_end: 7'd1};
        vecs[3] = '{dir: 1'b1, steps: 2, done_t: 41, pos_end: 7'd127};
        vecs[4] = '{dir: 1'b0, steps: 1, done_t: 21, pos_end: 7'd0};
        vecs[5] = '{dir: 1'b1, steps: 1, done_t: 21, pos_end: 7'd127};

        // Reset held for 3 cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rot", {ROT_A, ROT_B}, 2'b00);
        chk("rst_position", position, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        pos_model = 7'd0;
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].dir, vecs[i].steps, pos_model, vecs[i].done_t, vecs[i].pos_end);
            pos_model = vecs[i].pos_end;
        end

        // Back-to-back: second command held valid while busy, taken in the done cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_steps = 7'd1;
        @(posedge clk);
        #1;
        cmd_dir   = 1'b1;
        cmd_steps = 7'd1;
        track(1'b0, 1, 7'd127, 21, 7'd0, 21);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        track(1'b1, 1, 7'd0, 21, 7'd127, 21);

        // Reset during PH2 of the 2nd of 5 CCW detents.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 7'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        track(1'b1, 5, 7'd127, 101, 7'd122, 26);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rot", {ROT_A, ROT_B}, 2'b00);
        chk("abort_position", position, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", cmd_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        run_cmd(1'b0, 2, 7'd0, 41, 7'd2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
